// File: rtl/shape_table.sv
// Double-buffered shape parameter table. UART commands write the back bank; commit swaps on frame_start, then copies front to back.
// Optional build macro SHAPE_TABLE_DROP_CNT_EN adds the drop_cnt output.
module shape_table #(
   parameter int NUM_SHAPES = 16,
   parameter int NUM_REGS   = 8,
   parameter int DATA_W     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [11:0]       shape_addr,
   input  logic [11:0]       reg_addr,
   input  logic [DATA_W-1:0] data,
   input  logic              frame_start,
   input  logic [11:0]       rd_shape,
   input  logic [11:0]       rd_reg,
   output logic [DATA_W-1:0] rd_data,
   output logic              front_sel,
   output logic              swap_pulse,
   output logic              busy
`ifdef SHAPE_TABLE_DROP_CNT_EN
   ,output logic [15:0]      drop_cnt
`endif
);

   localparam int SW    = $clog2(NUM_SHAPES);
   localparam int RW    = $clog2(NUM_REGS);
   localparam int AW    = SW + RW;
   localparam int DEPTH = NUM_SHAPES * NUM_REGS;

   localparam logic [11:0]   COMMIT   = 12'hFFF;
   localparam logic [12:0]   NS_LIM   = 13'(NUM_SHAPES);
   localparam logic [12:0]   NR_LIM   = 13'(NUM_REGS);
   localparam logic [AW-1:0] COPY_END = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, PEND, COPY} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     copy_idx;
   logic              do_swap, copy_en;
   logic              wr_en, is_commit, wr_in_range;
   logic              rd_in_range;
   logic [AW-1:0]     wr_idx, rd_idx;
   logic [DATA_W-1:0] mem [2*DEPTH];

   assign is_commit   = (reg_addr == COMMIT);
   assign wr_in_range = ({1'b0, shape_addr} < NS_LIM) && ({1'b0, reg_addr} < NR_LIM);
   assign rd_in_range = ({1'b0, rd_shape} < NS_LIM) && ({1'b0, rd_reg} < NR_LIM);
   assign wr_idx      = {shape_addr[SW-1:0], reg_addr[RW-1:0]};
   assign rd_idx      = {rd_shape[SW-1:0], rd_reg[RW-1:0]};

   // Commit's 12'hFFF can never be in range, so it never writes storage
   assign wr_en    = wr_valid && wr_ready && wr_in_range;
   assign wr_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      do_swap   = 1'b0;
      copy_en   = 1'b0;
      case (state)
         IDLE: if (wr_valid && is_commit) state_nxt = PEND;
         PEND: begin
            if (frame_start) begin
               do_swap   = 1'b1;
               state_nxt = COPY;
            end
         end
         COPY: begin
            copy_en = 1'b1;
            if (copy_idx == COPY_END) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         front_sel  <= 1'b0;
         swap_pulse <= 1'b0;
         copy_idx   <= '0;
      end else begin
         state      <= state_nxt;
         swap_pulse <= do_swap;
         if (do_swap) begin
            front_sel <= ~front_sel;
            copy_idx  <= '0;
         end else if (copy_en) begin
            copy_idx  <= copy_idx + 1'b1;
         end
      end
   end

   // Storage and read port; the read uses front_sel before any swap on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
         for (int i = 0; i < 2*DEPTH; i++) mem[i] <= '0;
      end else begin
         rd_data <= rd_in_range ? mem[{front_sel, rd_idx}] : '0;
         if (wr_en)   mem[{~front_sel, wr_idx}]   <= data;
         if (copy_en) mem[{~front_sel, copy_idx}] <= mem[{front_sel, copy_idx}];
      end
   end

`ifdef SHAPE_TABLE_DROP_CNT_EN
   logic drop_evt;
   assign drop_evt = (wr_valid && !wr_ready) ||
                     (wr_valid && wr_ready && !is_commit && !wr_in_range);

   always_ff @(posedge clk) begin
      if (rst)                                drop_cnt <= '0;
      else if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule
